instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- clr  in  1  restart the load address at word 0 and clear err
- req_valid  in  1  encode request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_op  in  4  operation: 0 NOP, 1 ADDU, 2 SUBU, 3 ORI, 4 LUI, 5 LW, 6 SW, 7 BEQ, 8 JAL, 9 JR; 10-15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  16  immediate or offset
- req_target  in  26  jump target field
- im_we  out  1  instruction-memory write strobe
- im_addr  out  10  word index being written
- im_wdata  out  32  encoded instruction word
- pc_out  out  32  byte address of the written word: 0x00003000 + 4*im_addr
- count  out  11  number of words written since reset/clr, range 0..1024
- full  out  1  count == 1024
- err  out  1  sticky illegal-op flag

Function
REQ-003 Handshake: req_ready SHALL equal !full && !clr && !reset; a transfer occurs on a rising edge where req_valid && req_ready.
REQ-004 Latency: a request accepted on edge N SHALL appear on im_we/im_addr/im_wdata/pc_out for exactly the cycle after edge N; im_we SHALL be high for one cycle per accepted legal request.
REQ-005 Back-to-back accepts SHALL write consecutive addresses at one word per cycle with no bubbles.
REQ-006 Encodings SHALL be:
- ADDU {000000,rs,rt,rd,00000,100001}
- SUBU {000000,rs,rt,rd,00000,100011}
- ORI {001101,rs,rt,imm}
- LUI {001111,00000,rt,imm}
- LW {100011,rs,rt,imm}
- SW {101011,rs,rt,imm}
- BEQ {000100,rs,rt,imm}
- JAL {000011,target}
- JR {000000,rs,15'b0,001000}
- NOP 32'h0
REQ-007 Fields a format does not use SHALL be ignored.
REQ-008 The FSM SHALL have three states. IDLE→WRITE on accept. WRITE→WRITE on accept, else IDLE. Any state→FULL when count reaches 1024. FULL→IDLE only on clr or reset.
REQ-009 count SHALL increment on each write, and im_addr SHALL equal count[9:0] at accept time; the address SHALL never wrap, and full SHALL block further accepts.
REQ-010 clr SHALL take priority over req_valid in the same cycle: no accept. It SHALL set count=0 and err=0 and return to IDLE, while a write already presented in that cycle still completes.
REQ-011 The 1024th accept SHALL raise full on the same edge that presents its write.

Reset
REQ-012 On reset: state IDLE, count=0, full=0, err=0, im_we=0, im_addr=0, im_wdata=0, pc_out=0x00003000, and req_ready=0 during the reset cycle.
REQ-013 Reset mid-stream SHALL discard any pending write; im_we SHALL be low in the cycle after reset.

Configuration
REQ-014 With macro INSTR_ENC_ILLEGAL_CHECK_EN defined, an accepted illegal op SHALL set err (sticky) and produce no write, leaving count unchanged.
REQ-015 With INSTR_ENC_ILLEGAL_CHECK_EN undefined, an illegal op SHALL be written as NOP (32'h0) and count, while err SHALL stay 0.

Structure
REQ-016 Package instr_enc_pkg SHALL hold:
- the op enum
- opcode/funct constants
- IM_DEPTH=1024
- PC_BASE=32'h00003000
- the FSM state type
REQ-017 Combinational field packing SHALL live in the sub-module instr_field_pack (op and fields in; word and legal flag out), and instr_encoder SHALL hold the FSM, counters and output registers.

Verification
REQ-018 ADDU rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221821, pc_out=0x00003000.
REQ-019 Back-to-back ORI rt=1 imm=0x1234, then LUI rt=8 imm=0xFFFF, then SW rt=1 imm=4 -> words 0x34011234, 0x3C08FFFF, 0xAC010004 at addr 0,1,2 on consecutive cycles; count=3.
REQ-020 JAL target=0x0000C03 then JR rs=31 -> 0x0C000C03, then 0x03E00008.
REQ-021 1024 accepts -> full=1 and req_ready=0; a 1025th request is held with no im_we. Then clr -> count=0, and the next accept writes addr 0.
REQ-022 req_op=12 -> with macro: err=1, no im_we, count unchanged; without macro: im_we=1, im_wdata=0, err=0.
REQ-023 clr and req_valid in the same cycle -> no accept; reset asserted the cycle after an accept -> im_we=0 and count=0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// ============================================================================
// Module  : instr_enc_pkg
// Purpose : Shared op enum, opcode/funct constants, memory geometry, FSM state.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_enc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADDU = 4'd1,
        OP_SUBU = 4'd2,
        OP_ORI  = 4'd3,
        OP_LUI  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_JAL  = 4'd8,
        OP_JR   = 4'd9
    } op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_JAL     = 6'b000011;

    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;

    localparam int          IM_DEPTH = 1024;
    localparam int          ADDR_W   = 10;
    localparam int          CNT_W    = 11;
    localparam logic [31:0] PC_BASE  = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
// Module  : instr_field_pack
// Purpose : Combinational packing of op + register/immediate fields into a word.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_pack (
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);
    import instr_enc_pkg::*;

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (op_e'(op_i))
            OP_NOP:  word_o = '0;
            OP_ADDU: word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_ADDU};
            OP_SUBU: word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_SUBU};
            OP_ORI:  word_o = {OPC_ORI, rs_i, rt_i, imm_i};
            OP_LUI:  word_o = {OPC_LUI, 5'd0, rt_i, imm_i};
            OP_LW:   word_o = {OPC_LW, rs_i, rt_i, imm_i};
            OP_SW:   word_o = {OPC_SW, rs_i, rt_i, imm_i};
            OP_BEQ:  word_o = {OPC_BEQ, rs_i, rt_i, imm_i};
            OP_JAL:  word_o = {OPC_JAL, target_i};
            OP_JR:   word_o = {OPC_SPECIAL, rs_i, 15'd0, FUNCT_JR};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Purpose : Accepts encode requests and streams packed words into instruction
//           memory. Define INSTR_ENC_ILLEGAL_CHECK_EN to drop illegal ops and
//           flag err instead of writing them as NOP.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    output logic        im_we,
    output logic [9:0]  im_addr,
    output logic [31:0] im_wdata,
    output logic [31:0] pc_out,
    output logic [10:0] count,
    output logic        full,
    output logic        err
);
    import instr_enc_pkg::*;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         pc_q, pc_d;

    logic [31:0]         pack_word;
    logic                pack_legal;
    logic                accept;
    logic                do_write;
    logic                set_err;
    logic [31:0]         write_word;

    instr_field_pack u_pack (
        .op_i     (req_op),
        .rs_i     (req_rs),
        .rt_i     (req_rt),
        .rd_i     (req_rd),
        .imm_i    (req_imm),
        .target_i (req_target),
        .word_o   (pack_word),
        .legal_o  (pack_legal)
    );

    assign req_ready = (state_q != S_FULL) && !clr && !reset;
    assign accept    = req_valid && req_ready;

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
    assign do_write   = accept && pack_legal;
    assign set_err    = accept && !pack_legal;
    assign write_word = pack_word;
`else
    assign do_write   = accept;
    assign set_err    = 1'b0;
    assign write_word = pack_legal ? pack_word : 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;

        if (do_write) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = write_word;
            pc_d    = PC_BASE + {20'd0, count_q[ADDR_W-1:0], 2'b00};
            count_d = count_q + CNT_W'(1);
        end
        if (set_err) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE:  if (accept) state_d = S_WRITE;
            S_WRITE: state_d = accept ? S_WRITE : S_IDLE;
            S_FULL:  state_d = S_FULL;
            default: state_d = S_IDLE;
        endcase
        // Reaching depth raises full on the same edge that presents the last write.
        if (count_d == CNT_W'(IM_DEPTH)) begin
            state_d = S_FULL;
        end

        if (clr) begin
            count_d = '0;
            err_d   = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= PC_BASE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign pc_out   = pc_q;
    assign count    = count_q;
    assign full     = (state_q == S_FULL);
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module  : tb_instr_encoder
// Purpose : Scoreboard bench for instr_encoder against an arithmetic encoder model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, clr, req_valid, req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        im_we, full, err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata, pc_out;
    logic [10:0] count;

    instr_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .req_target (req_target),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .pc_out     (pc_out),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_count  = 0;
    bit  m_err    = 1'b0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoding model built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                               input int rd, input int imm, input int tgt);
        longint w;
        case (op)
            1:       w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 33;
            2:       w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 35;
            3:       w = 13 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            4:       w = 15 * 64'd67108864 + rt * 64'd65536 + imm;
            5:       w = 35 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            6:       w = 43 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            7:       w = 4 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            8:       w = 3 * 64'd67108864 + tgt;
            9:       w = rs * 64'd2097152 + 8;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic cycle(input bit rst, input bit c, input bit v, input int op,
                         input int rs, input int rt, input int rd, input int imm,
                         input int tgt, input bit has_lit = 1'b0,
                         input logic [31:0] lit = 32'h0);
        bit  exp_ready;
        wr_t w;
        reset      = rst;
        clr        = c;
        req_valid  = v;
        req_op     = 4'(op);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_imm    = 16'(imm);
        req_target = 26'(tgt);
        #1;
        exp_ready = (m_count != 1024) && !c && !rst;
        if (mon_en) check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        @(posedge clk);
        if (rst) begin
            m_count = 0;
            m_err   = 1'b0;
            exp_q.delete();
        end else if (c) begin
            m_count = 0;
            m_err   = 1'b0;
        end else if (v && exp_ready) begin
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
            if (op > 9) begin
                m_err = 1'b1;
            end else begin
`else
            begin
`endif
                w.addr = 10'(m_count);
                w.data = has_lit ? lit : ref_encode(op, rs, rt, rd, imm, tgt);
                w.pc   = 32'h0000_3000 + 32'(4 * m_count);
                exp_q.push_back(w);
                m_count++;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rst, input bit c);
        cycle(rst, c, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic req(input int op, input int rs, input int rt, input int rd,
                       input int imm, input int tgt, input bit has_lit = 1'b0,
                       input logic [31:0] lit = 32'h0);
        cycle(1'b0, 1'b0, 1'b1, op, rs, rt, rd, imm, tgt, has_lit, lit);
    endtask

    task automatic rand_req(input int max_op);
        req($urandom_range(0, max_op), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
    endtask

    // Monitor: every pushed write must appear on the next cycle, nothing else may.
    always @(negedge clk) begin
        if (mon_en) begin
            check("im_we", {31'd0, im_we}, {31'd0, exp_q.size() != 0});
            if (im_we && exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("im_addr", {22'd0, im_addr}, {22'd0, w.addr});
                check("im_wdata", im_wdata, w.data);
                check("pc_out", pc_out, w.pc);
            end
            check("count", {21'd0, count}, 32'(m_count));
            check("full", {31'd0, full}, {31'd0, m_count == 1024});
            check("err", {31'd0, err}, {31'd0, m_err});
        end
    end

    initial begin
        reset = 1'b1; clr = 1'b0; req_valid = 1'b0; req_op = '0;
        req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
        idle(1'b1, 1'b0);
        mon_en = 1'b1;
        idle(1'b1, 1'b0);
        check("reset_im_addr", {22'd0, im_addr}, 32'd0);
        check("reset_im_wdata", im_wdata, 32'd0);
        check("reset_pc_out", pc_out, 32'h0000_3000);
        idle(1'b0, 1'b0);

        req(1, 1, 2, 3, 0, 0, 1'b1, 32'h0022_1821);
        idle(1'b0, 1'b1);

        req(3, 0, 1, 0, 16'h1234, 0, 1'b1, 32'h3401_1234);
        req(4, 0, 8, 0, 16'hFFFF, 0, 1'b1, 32'h3C08_FFFF);
        req(6, 0, 1, 0, 4, 0, 1'b1, 32'hAC01_0004);
        idle(1'b0, 1'b0);
        check("count_after_3", {21'd0, count}, 32'd3);

        req(8, 0, 0, 0, 0, 26'h0000C03, 1'b1, 32'h0C00_0C03);
        req(9, 31, 0, 0, 0, 0, 1'b1, 32'h03E0_0008);
        idle(1'b0, 1'b0);

        req(12, 5, 6, 7, 16'h55AA, 26'h3FFFFFF, 1'b1, 32'h0);
        idle(1'b0, 1'b0);

        cycle(1'b0, 1'b1, 1'b1, 1, 1, 2, 3, 0, 0);
        idle(1'b0, 1'b0);
        req(2, 4, 5, 6, 0, 0);
        idle(1'b1, 1'b0);
        check("count_after_reset", {21'd0, count}, 32'd0);
        idle(1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)       idle(1'b1, 1'b0);
            else if (r < 9)  cycle(1'b0, 1'b1, 1'b1, 1, 1, 1, 1, 1, 1);
            else if (r < 30) idle(1'b0, 1'b0);
            else             rand_req(15);
        end

        idle(1'b0, 1'b1);
        while (m_count < 1024) rand_req(9);
        check("full_at_1024", {31'd0, full}, 32'd1);
        for (int i = 0; i < 3; i++) req(1, 1, 2, 3, 0, 0);
        check("ready_when_full", {31'd0, req_ready}, 32'd0);
        idle(1'b0, 1'b1);
        check("count_after_clr", {21'd0, count}, 32'd0);
        req(1, 1, 2, 3, 0, 0, 1'b1, 32'h0022_1821);
        idle(1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
